// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: latches rising edges of external IRQ lines and presents one at a time
// to the core. Define INTERRUPT_ARBITER_ROUND_ROBIN_EN for rotating priority (default: lowest index wins).
module interrupt_arbiter #(
  parameter int EXT_IRQ_COUNT = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [EXT_IRQ_COUNT-1:0] irqBus,
  input  logic                     maskWe,
  input  logic [EXT_IRQ_COUNT-1:0] maskData,
  input  logic                     intAck,
  input  logic                     intDone,
  output logic                     interrupt,
  output logic [31:0]              intCode,
  output logic [EXT_IRQ_COUNT-1:0] pending
);

  localparam int IDX_W = (EXT_IRQ_COUNT > 1) ? $clog2(EXT_IRQ_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, REQUEST, ACTIVE} arbState_t;

  arbState_t state;
  arbState_t stateNext;

  logic [EXT_IRQ_COUNT-1:0] irqPrev;
  logic [EXT_IRQ_COUNT-1:0] mask;
  logic [EXT_IRQ_COUNT-1:0] maskEff;
  logic [EXT_IRQ_COUNT-1:0] eligible;
  logic [EXT_IRQ_COUNT-1:0] risingEdge;
  logic [EXT_IRQ_COUNT-1:0] clearVec;
  logic [IDX_W-1:0]         curIdx;
  logic [IDX_W-1:0]         winnerIdx;
  logic                     winnerValid;
  logic                     curEligible;
  logic                     grant;
  logic                     ackTake;
  logic                     withdraw;
  logic [31:0]              winnerCode;

  assign risingEdge  = irqBus & ~irqPrev;
  assign eligible    = pending & mask;
  // A mask write in the same cycle can already withdraw the presented request.
  assign maskEff     = maskWe ? maskData : mask;
  assign curEligible = pending[curIdx] & maskEff[curIdx];
  assign winnerCode  = 32'h8000_0000 | (32'd16 + 32'(winnerIdx));

`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] lastIdx;

  function automatic logic [IDX_W-1:0] rotIdx(input logic [IDX_W-1:0] base, input int off);
    int cand;
    cand = int'(base) + 1 + off;
    if (cand >= EXT_IRQ_COUNT) cand = cand - EXT_IRQ_COUNT;
    return IDX_W'(cand);
  endfunction

  // Walk backwards so the candidate closest to lastIdx+1 is the final assignment.
  always_comb begin
    winnerIdx   = '0;
    winnerValid = 1'b0;
    for (int off = EXT_IRQ_COUNT - 1; off >= 0; off--) begin
      if (eligible[rotIdx(lastIdx, off)]) begin
        winnerIdx   = rotIdx(lastIdx, off);
        winnerValid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lastIdx <= '0;
    end else if (ackTake) begin
      lastIdx <= curIdx;
    end
  end
`else
  always_comb begin
    winnerIdx   = '0;
    winnerValid = 1'b0;
    for (int i = EXT_IRQ_COUNT - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winnerIdx   = IDX_W'(i);
        winnerValid = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (winnerValid) stateNext = REQUEST;
      end
      REQUEST: begin
        if (intAck) stateNext = ACTIVE;
        else if (!curEligible) stateNext = IDLE;
      end
      ACTIVE: begin
        if (intDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    grant    = 1'b0;
    ackTake  = 1'b0;
    withdraw = 1'b0;
    clearVec = '0;
    case (state)
      IDLE: begin
        grant = winnerValid;
      end
      REQUEST: begin
        ackTake  = intAck;
        withdraw = !intAck && !curEligible;
        if (intAck) clearVec[curIdx] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // A fresh rising edge on the line being acknowledged re-arms its pending bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irqPrev   <= '0;
      mask      <= '1;
      pending   <= '0;
      curIdx    <= '0;
      interrupt <= 1'b0;
      intCode   <= '0;
    end else begin
      irqPrev <= irqBus;
      pending <= (pending & ~clearVec) | risingEdge;
      if (maskWe) mask <= maskData;
      if (grant) begin
        curIdx    <= winnerIdx;
        interrupt <= 1'b1;
        intCode   <= winnerCode;
      end else if (ackTake || withdraw) begin
        interrupt <= 1'b0;
        intCode   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Scoreboard bench for interrupt_arbiter: each driven cycle pushes the expected post-edge
// outputs, a monitor pops and compares them after every rising edge.
module tb_interrupt_arbiter;

  localparam logic [31:0] C0 = 32'h8000_0010;
  localparam logic [31:0] C1 = 32'h8000_0011;
  localparam logic [31:0] C2 = 32'h8000_0012;
  localparam logic [31:0] C3 = 32'h8000_0013;

`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
  localparam logic [31:0] SIM_FIRST  = C3;
  localparam logic [31:0] SIM_SECOND = C1;
  localparam logic [3:0]  SIM_MID    = 4'b0010;
  localparam logic [31:0] PRI_FIRST  = C3;
  localparam logic [31:0] PRI_SECOND = C0;
  localparam logic [3:0]  PRI_MID    = 4'b0001;
  localparam logic [31:0] REL_FIRST  = C1;
  localparam logic [3:0]  REL_MID    = 4'b1101;
  localparam logic [31:0] REL_NEXT   = C2;
`else
  localparam logic [31:0] SIM_FIRST  = C1;
  localparam logic [31:0] SIM_SECOND = C3;
  localparam logic [3:0]  SIM_MID    = 4'b1000;
  localparam logic [31:0] PRI_FIRST  = C0;
  localparam logic [31:0] PRI_SECOND = C3;
  localparam logic [3:0]  PRI_MID    = 4'b1000;
  localparam logic [31:0] REL_FIRST  = C0;
  localparam logic [3:0]  REL_MID    = 4'b1110;
  localparam logic [31:0] REL_NEXT   = C1;
`endif

  typedef struct {
    logic        eInt;
    logic [31:0] eCode;
    logic [3:0]  ePend;
  } expItem_t;

  logic        clk;
  logic        rstn;
  logic [3:0]  irqBus;
  logic        maskWe;
  logic [3:0]  maskData;
  logic        intAck;
  logic        intDone;
  logic        interrupt;
  logic [31:0] intCode;
  logic [3:0]  pending;

  expItem_t sbQ[$];
  string    tagQ[$];
  expItem_t curExp;
  string    curTag;
  int       checkCount;
  int       errorCount;

  interrupt_arbiter #(.EXT_IRQ_COUNT(4)) dut (
    .clk(clk),
    .rstn(rstn),
    .irqBus(irqBus),
    .maskWe(maskWe),
    .maskData(maskData),
    .intAck(intAck),
    .intDone(intDone),
    .interrupt(interrupt),
    .intCode(intCode),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
    end
  endtask

  // One cycle: drive inputs on the falling edge, queue what must be seen after the next rising edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic [3:0] irq,
                               input logic we, input logic [3:0] md, input logic ack,
                               input logic done, input logic eInt, input logic [31:0] eCode,
                               input logic [3:0] ePend);
    expItem_t item;
    @(negedge clk);
    rstn     = rst;
    irqBus   = irq;
    maskWe   = we;
    maskData = md;
    intAck   = ack;
    intDone  = done;
    item.eInt  = eInt;
    item.eCode = eCode;
    item.ePend = ePend;
    sbQ.push_back(item);
    tagQ.push_back(tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbQ.size() != 0) begin
      curExp = sbQ.pop_front();
      curTag = tagQ.pop_front();
      checkOutput({curTag, ".interrupt"}, 32'(interrupt), 32'(curExp.eInt));
      checkOutput({curTag, ".intCode"}, intCode, curExp.eCode);
      checkOutput({curTag, ".pending"}, 32'(pending), 32'(curExp.ePend));
    end
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    rstn     = 1'b0;
    irqBus   = 4'b0000;
    maskWe   = 1'b0;
    maskData = 4'b0000;
    intAck   = 1'b0;
    intDone  = 1'b0;

    // Reset held while lines toggle
    applyStimulus("rst0", 0, 4'b0101, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0000);
    applyStimulus("rst1", 0, 4'b1111, 0, 4'h0, 1, 1, 0, 32'h0, 4'b0000);
    applyStimulus("rst2", 0, 4'b0000, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0000);
    applyStimulus("idle0", 1, 4'b0000, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0000);
    applyStimulus("idle1", 1, 4'b0000, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0000);

    // Single line 2
    applyStimulus("single.edge", 1, 4'b0100, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0100);
    applyStimulus("single.req", 1, 4'b0100, 0, 4'h0, 0, 0, 1, C2, 4'b0100);
    applyStimulus("single.hold", 1, 4'b0100, 0, 4'h0, 0, 0, 1, C2, 4'b0100);
    applyStimulus("single.ack", 1, 4'b0100, 0, 4'h0, 1, 0, 0, 32'h0, 4'b0000);
    applyStimulus("single.active", 1, 4'b0000, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0000);
    applyStimulus("single.done", 1, 4'b0000, 0, 4'h0, 0, 1, 0, 32'h0, 4'b0000);
    applyStimulus("single.idle", 1, 4'b0000, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0000);

    // Simultaneous lines 1 and 3
    applyStimulus("sim.edge", 1, 4'b1010, 0, 4'h0, 0, 0, 0, 32'h0, 4'b1010);
    applyStimulus("sim.req1", 1, 4'b1010, 0, 4'h0, 0, 0, 1, SIM_FIRST, 4'b1010);
    applyStimulus("sim.ack1", 1, 4'b1010, 0, 4'h0, 1, 0, 0, 32'h0, SIM_MID);
    applyStimulus("sim.done1", 1, 4'b0000, 0, 4'h0, 0, 1, 0, 32'h0, SIM_MID);
    applyStimulus("sim.req2", 1, 4'b0000, 0, 4'h0, 0, 0, 1, SIM_SECOND, SIM_MID);
    applyStimulus("sim.ack2", 1, 4'b0000, 0, 4'h0, 1, 0, 0, 32'h0, 4'b0000);
    applyStimulus("sim.done2", 1, 4'b0000, 0, 4'h0, 0, 1, 0, 32'h0, 4'b0000);

    // Lines 0 and 3: fixed picks 0, rotation after line 1 picks 3
    applyStimulus("pri.edge", 1, 4'b1001, 0, 4'h0, 0, 0, 0, 32'h0, 4'b1001);
    applyStimulus("pri.req1", 1, 4'b1001, 0, 4'h0, 0, 0, 1, PRI_FIRST, 4'b1001);
    applyStimulus("pri.ack1", 1, 4'b1001, 0, 4'h0, 1, 0, 0, 32'h0, PRI_MID);
    applyStimulus("pri.done1", 1, 4'b0000, 0, 4'h0, 0, 1, 0, 32'h0, PRI_MID);
    applyStimulus("pri.req2", 1, 4'b0000, 0, 4'h0, 0, 0, 1, PRI_SECOND, PRI_MID);
    applyStimulus("pri.ack2", 1, 4'b0000, 0, 4'h0, 1, 0, 0, 32'h0, 4'b0000);
    applyStimulus("pri.done2", 1, 4'b0000, 0, 4'h0, 0, 1, 0, 32'h0, 4'b0000);

    // Masked line still latches pending; unmask uses old mask in the write cycle
    applyStimulus("mask.wr", 1, 4'b0000, 1, 4'b1110, 0, 0, 0, 32'h0, 4'b0000);
    applyStimulus("mask.edge", 1, 4'b0001, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0001);
    applyStimulus("mask.blocked0", 1, 4'b0000, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0001);
    applyStimulus("mask.blocked1", 1, 4'b0000, 0, 4'h0, 1, 1, 0, 32'h0, 4'b0001);
    applyStimulus("mask.unmask", 1, 4'b0000, 1, 4'b1111, 0, 0, 0, 32'h0, 4'b0001);
    applyStimulus("mask.req", 1, 4'b0000, 0, 4'h0, 0, 0, 1, C0, 4'b0001);
    applyStimulus("mask.ack", 1, 4'b0000, 0, 4'h0, 1, 0, 0, 32'h0, 4'b0000);
    applyStimulus("mask.done", 1, 4'b0000, 0, 4'h0, 0, 1, 0, 32'h0, 4'b0000);

    // Withdraw on mask-off, then mask-off together with ack
    applyStimulus("wd.edge", 1, 4'b0100, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0100);
    applyStimulus("wd.req", 1, 4'b0100, 0, 4'h0, 0, 0, 1, C2, 4'b0100);
    applyStimulus("wd.withdraw", 1, 4'b0100, 1, 4'b1011, 0, 0, 0, 32'h0, 4'b0100);
    applyStimulus("wd.idle", 1, 4'b0100, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0100);
    applyStimulus("wd.unmask", 1, 4'b0100, 1, 4'b1111, 0, 0, 0, 32'h0, 4'b0100);
    applyStimulus("wd.rereq", 1, 4'b0100, 0, 4'h0, 0, 0, 1, C2, 4'b0100);
    applyStimulus("wd.ackwins", 1, 4'b0100, 1, 4'b1011, 1, 0, 0, 32'h0, 4'b0000);
    applyStimulus("wd.done", 1, 4'b0000, 0, 4'h0, 0, 1, 0, 32'h0, 4'b0000);
    applyStimulus("wd.restore", 1, 4'b0000, 1, 4'b1111, 0, 0, 0, 32'h0, 4'b0000);

    // New edge on the serviced line in the ack cycle
    applyStimulus("ea.edge", 1, 4'b0010, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0010);
    applyStimulus("ea.req", 1, 4'b0000, 0, 4'h0, 0, 0, 1, C1, 4'b0010);
    applyStimulus("ea.ackedge", 1, 4'b0010, 0, 4'h0, 1, 0, 0, 32'h0, 4'b0010);
    applyStimulus("ea.active", 1, 4'b0000, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0010);
    applyStimulus("ea.done", 1, 4'b0000, 0, 4'h0, 0, 1, 0, 32'h0, 4'b0010);
    applyStimulus("ea.rereq", 1, 4'b0000, 0, 4'h0, 0, 0, 1, C1, 4'b0010);

    // Reset pulse in REQUEST, release with all lines high
    applyStimulus("rq.reset", 0, 4'b0010, 0, 4'h0, 0, 0, 0, 32'h0, 4'b0000);
    applyStimulus("rq.release", 1, 4'b1111, 0, 4'h0, 0, 0, 0, 32'h0, 4'b1111);
    applyStimulus("rq.req1", 1, 4'b1111, 0, 4'h0, 0, 0, 1, REL_FIRST, 4'b1111);
    applyStimulus("rq.ack1", 1, 4'b1111, 0, 4'h0, 1, 0, 0, 32'h0, REL_MID);
    applyStimulus("rq.done1", 1, 4'b1111, 0, 4'h0, 0, 1, 0, 32'h0, REL_MID);
    applyStimulus("rq.req2", 1, 4'b1111, 0, 4'h0, 0, 0, 1, REL_NEXT, REL_MID);

    for (int n = 0; n < 8 && sbQ.size() != 0; n++) @(posedge clk);
    #2;
    if (sbQ.size() != 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL drain got %0d entries expected 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
